// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge ROM/RAM controller.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    HOLD  = 2'd3
  } cart_st_t;

  localparam logic [15:0] CART_MAX  = 16'h4000;
  localparam logic [15:0] BANK0_MIN = 16'h1000;
  localparam logic [15:0] BANK1_MIN = 16'h2000;
  localparam logic [13:0] RAM_BASE  = 14'h3C00;

endpackage

// File: rtl/cart_bank_map.sv
// Maps a CPU cart address plus BS0/BS1 onto the cart RAM address, gating each bank
// select by the loaded cart size. With CART_RAM_EN the top 1 KB window is remapped.
module cart_bank_map
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned SIZE_W = 16
) (
  input  logic [11:0]       cpu_addr,
  input  logic              cpu_bs0,
  input  logic              cpu_bs1,
  input  logic [SIZE_W-1:0] cart_size,
`ifdef CART_RAM_EN
  output logic              ram_hit,
`endif
  output logic [ADDR_W-1:0] map_addr
);

  logic        bank0_en;
  logic        bank1_en;
  logic [12:0] rom_addr;

  // A bank bit only takes effect once the cart is big enough to contain that bank.
  assign bank0_en = cpu_bs0 && (cart_size >= SIZE_W'(BANK0_MIN));
  assign bank1_en = cpu_bs1 && (cart_size >= SIZE_W'(BANK1_MIN));

  // cpu_addr[10] is dropped: the 1 KB halves are mirrors of each other.
  assign rom_addr = {bank1_en, bank0_en, cpu_addr[11], cpu_addr[9:0]};

`ifdef CART_RAM_EN
  assign ram_hit  = (cpu_addr[11:10] == 2'b11) && (cart_size <= SIZE_W'(RAM_BASE));
  assign map_addr = ram_hit ? (ADDR_W'(RAM_BASE) + ADDR_W'(cpu_addr[9:0])) : ADDR_W'(rom_addr);
`else
  logic unused_mirror_bit;
  assign unused_mirror_bit = cpu_addr[10];
  assign map_addr          = ADDR_W'(rom_addr);
`endif

endmodule

// File: rtl/cart_mem_ctrl.sv
// Cart RAM port owner: byte-splits HPS download words, serves CPU fetches, tracks cart size
// and holds the console in reset around downloads. Optional cart RAM window: CART_RAM_EN.
module cart_mem_ctrl
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned SIZE_W       = 16,
  parameter int unsigned POST_DL_HOLD = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic [11:0]       cpu_addr,
  input  logic              cpu_psen_n,
  input  logic              cpu_bs0,
  input  logic              cpu_bs1,
`ifdef CART_RAM_EN
  input  logic              cpu_wr_n,
  input  logic [7:0]        cpu_din,
`endif
  output logic [7:0]        cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_q,
  output logic [SIZE_W-1:0] cart_size,
  output logic              console_res_n
);

  localparam int unsigned HOLD_W = (POST_DL_HOLD < 2) ? 1 : $clog2(POST_DL_HOLD + 1);

  cart_st_t            state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [15:0]         wr_data_q;
  logic                wr_drop_q;
  logic                dl_q;
  logic                in_dl_q;
  logic                rd_valid_q;
  logic                dl_rise;
  logic                cpu_ok;
  logic [SIZE_W-1:0]   wr_end;
  logic [SIZE_W-1:0]   wr_end_sat;
  logic [ADDR_W-1:0]   map_addr;

  assign dl_rise = ioctl_download && !dl_q;
  // CPU owns the port only when idle and no download is running or still being wound down.
  assign cpu_ok  = (state_q == IDLE) && !ioctl_download && !in_dl_q;

  assign wr_end     = SIZE_W'(wr_addr_q) + SIZE_W'(2);
  assign wr_end_sat = (wr_end > SIZE_W'(CART_MAX)) ? SIZE_W'(CART_MAX) : wr_end;

`ifdef CART_RAM_EN
  logic ram_hit;
  logic cpu_wr_n_q;
  logic cpu_wr_fire;
  // One write per falling edge of cpu_wr_n, so a held strobe writes only once.
  assign cpu_wr_fire = cpu_ok && ram_hit && !cpu_wr_n && cpu_wr_n_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_wr_n_q <= 1'b1;
    end else begin
      cpu_wr_n_q <= cpu_wr_n;
    end
  end
`endif

  cart_bank_map #(
    .ADDR_W (ADDR_W),
    .SIZE_W (SIZE_W)
  ) u_bank_map (
    .cpu_addr  (cpu_addr),
    .cpu_bs0   (cpu_bs0),
    .cpu_bs1   (cpu_bs1),
    .cart_size (cart_size),
`ifdef CART_RAM_EN
    .ram_hit   (ram_hit),
`endif
    .map_addr  (map_addr)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= HOLD;
      hold_cnt_q    <= HOLD_W'(POST_DL_HOLD);
      cart_size     <= '0;
      console_res_n <= 1'b0;
      ioctl_wait    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_drop_q     <= 1'b0;
      dl_q          <= 1'b0;
      in_dl_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      rd_valid_q <= cpu_ok && !cpu_psen_n;
      unique case (state_q)
        IDLE: begin
          if (ioctl_download) begin
            console_res_n <= 1'b0;
          end
          if (dl_rise) begin
            cart_size <= '0;
            in_dl_q   <= 1'b1;
          end
          if (ioctl_download && ioctl_wr) begin
            wr_addr_q  <= ioctl_addr[ADDR_W-1:0];
            wr_data_q  <= ioctl_dout;
            wr_drop_q  <= |ioctl_addr[24:ADDR_W];
            ioctl_wait <= 1'b1;
            state_q    <= WR_LO;
          end else if (in_dl_q && !ioctl_download) begin
            in_dl_q    <= 1'b0;
            hold_cnt_q <= HOLD_W'(POST_DL_HOLD);
            state_q    <= HOLD;
          end
        end
        WR_LO: begin
          state_q <= WR_HI;
        end
        WR_HI: begin
          if (!wr_drop_q && (wr_end_sat > cart_size)) begin
            cart_size <= wr_end_sat;
          end
          ioctl_wait <= 1'b0;
          state_q    <= IDLE;
        end
        HOLD: begin
          if (dl_rise) begin
            cart_size <= '0;
            in_dl_q   <= 1'b1;
            state_q   <= IDLE;
          end else if (hold_cnt_q <= HOLD_W'(1)) begin
            hold_cnt_q    <= '0;
            console_res_n <= 1'b1;
            state_q       <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  // Port mux: download bytes win; the CPU address is only presented from IDLE.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    unique case (state_q)
      WR_LO: begin
        mem_addr = wr_addr_q;
        mem_din  = wr_data_q[7:0];
        mem_we   = !wr_drop_q;
      end
      WR_HI: begin
        mem_addr = wr_addr_q + ADDR_W'(1);
        mem_din  = wr_data_q[15:8];
        mem_we   = !wr_drop_q;
      end
      IDLE: begin
        if (cpu_ok) begin
          mem_addr = map_addr;
`ifdef CART_RAM_EN
          if (cpu_wr_fire) begin
            mem_din = cpu_din;
            mem_we  = 1'b1;
          end
`endif
        end
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign cpu_data = rd_valid_q ? mem_q : 8'hFF;

endmodule
